float_result_queue: RTL and testbench

FLOAT_RESULT_QUEUE -- requirements
Module: float_result_queue

---
 rtl/float_result_queue_pkg.sv | 31 +++
 rtl/float_result_fifo_mem.sv | 38 +++
 rtl/float_result_queue.sv | 94 +++++++++
 tb/tb_float_result_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/float_result_queue_pkg.sv
// Shared float definitions for the result queue: flag bit indices, widths,
// half-precision constants and the packed queue entry.
package float_result_queue_pkg;

    localparam int FLAG_W   = 5;
    localparam int FLAG_NV  = 4;
    localparam int FLAG_DZ  = 3;
    localparam int FLAG_OF  = 2;
    localparam int FLAG_UF  = 1;
    localparam int FLAG_NX  = 0;
    localparam int RESULT_W = 32;
    localparam int ENTRY_W  = RESULT_W + FLAG_W;

    localparam logic [15:0] INF_H  = 16'h7C00;
    localparam logic [15:0] NAN_H  = 16'h7E00;
    localparam logic [15:0] ZERO_H = 16'h0000;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic [FLAG_W-1:0]   flags;
    } entry_t;

    function automatic entry_t pack_entry(input logic [RESULT_W-1:0] r,
                                          input logic [FLAG_W-1:0] f);
        entry_t e;
        e.result = r;
        e.flags  = f;
        return e;
    endfunction

endpackage

// File: rtl/float_result_fifo_mem.sv
// Circular storage for the result queue. Pointers wrap modulo DEPTH (a power
// of two); occupancy tracking lives in the parent.
module float_result_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Data array has no reset; the parent masks it whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/float_result_queue.sv
// Result queue between float_alu and its consumer, with optional sticky
// exception-flag accumulation enabled by FLOAT_STICKY_FLAGS_EN.
module float_result_queue
    import float_result_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [RESULT_W-1:0]     result_in,
    input  logic [FLAG_W-1:0]       flags_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [RESULT_W-1:0]     result,
    output logic [FLAG_W-1:0]       flags,
    output logic [$clog2(DEPTH):0]  count,
`ifdef FLOAT_STICKY_FLAGS_EN
    output logic [FLAG_W-1:0]       sticky_flags,
`endif
    input  logic                    clear_flags
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshake: a transfer happens on any rising edge where valid and ready are
    // both high; valid never waits on ready, and ready_out has no pop lookahead.
    logic   started;
    logic   push;
    logic   pop;
    entry_t head_mem;
    entry_t last_q;
    entry_t head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    assign ready_out = started && (count != FULL_CNT);
    assign valid_out = (count != '0);
    assign push      = valid_in && ready_out;
    assign pop       = valid_out && ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    float_result_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (pack_entry(result_in, flags_in)),
        .rd_en   (pop),
        .rd_data (head_mem)
    );

    // When empty the outputs show the most recently popped entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last_q <= '0;
        else if (pop) last_q <= head_mem;
    end

    assign head   = valid_out ? head_mem : last_q;
    assign result = head.result;
    assign flags  = head.flags;

`ifdef FLOAT_STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else if (push) begin
            sticky_flags <= (clear_flags ? '0 : sticky_flags) | flags_in;
        end else if (clear_flags) begin
            sticky_flags <= '0;
        end
    end
`else
    logic unused_clear_flags;
    assign unused_clear_flags = clear_flags;
`endif

endmodule

// File: tb/tb_float_result_queue.sv
// Directed bench for float_result_queue; the sticky-flag scenario runs only
// when FLOAT_STICKY_FLAGS_EN is defined.
module tb_float_result_queue;
    import float_result_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] result_in;
    logic [4:0]  flags_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic [4:0]  flags;
    logic [2:0]  count;
    logic        clear_flags;
`ifdef FLOAT_STICKY_FLAGS_EN
    logic [4:0]  sticky_flags;
`endif

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_e;

    always #5 clk = ~clk;

    float_result_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .result_in    (result_in),
        .flags_in     (flags_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .result       (result),
        .flags        (flags),
        .count        (count),
`ifdef FLOAT_STICKY_FLAGS_EN
        .sticky_flags (sticky_flags),
`endif
        .clear_flags  (clear_flags)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] r, input logic [4:0] f);
        valid_in  = 1'b1;
        result_in = r;
        flags_in  = f;
        step();
        valid_in  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b0; clear_flags = 1'b0;
        result_in = '0; flags_in = '0;
        #2;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready_out); end
        checks++; if ({result, flags} !== 37'h0) begin failures++; $display("FAIL reset_head: got %h expected 0", {result, flags}); end
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL ready_before_edge: got %b expected 0", ready_out); end
        step();
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL ready_after_edge: got %b expected 1", ready_out); end
    endtask

    task automatic test_single();
        ready_in = 1'b1;
        push_one(32'h0000_489C, 5'h00);
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", valid_out); end
        checks++; if (result !== 32'h0000_489C) begin failures++; $display("FAIL single_result: got %h expected 0000489c", result); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1: got %0d expected 1", count); end
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count0: got %0d expected 0", count); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL single_empty: got %b expected 0", valid_out); end
        checks++; if (result !== 32'h0000_489C) begin failures++; $display("FAIL single_last_held: got %h expected 0000489c", result); end
        ready_in = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] vr [4];
        vr = '{32'h3C00, 32'hBC92, 32'h3BE1, 32'h348A};
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_one(vr[i], 5'(1 << i));
            exp_q.push_back({vr[i], 5'(1 << i)});
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d expected 4", count); end
        checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b expected 0", ready_out); end
        push_one(32'h1234, 5'h1F);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_ignored: got %0d expected 4", count); end
        checks++; if ({result, flags} !== exp_q[0]) begin failures++; $display("FAIL fill_head_stable: got %h expected %h", {result, flags}, exp_q[0]); end
        ready_in = 1'b1;
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++; if ({result, flags} !== exp_e) begin failures++; $display("FAIL fill_drain: got %h expected %h", {result, flags}, exp_e); end
            step();
        end
        ready_in = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fill_drained: got %0d expected 0", count); end
    endtask

    task automatic test_full_pop_push();
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_one(32'h4000 + 32'(i), 5'(i + 8));
            exp_q.push_back({32'h4000 + 32'(i), 5'(i + 8)});
        end
        valid_in = 1'b1; result_in = 32'hAAAA; flags_in = 5'h1F; ready_in = 1'b1;
        step();
        valid_in = 1'b0; ready_in = 1'b0;
        void'(exp_q.pop_front());
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL fullpp_count: got %0d expected 3", count); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL fullpp_ready: got %b expected 1", ready_out); end
        ready_in = 1'b1;
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++; if ({result, flags} !== exp_e) begin failures++; $display("FAIL fullpp_drain: got %h expected %h", {result, flags}, exp_e); end
            step();
        end
        ready_in = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL fullpp_drained: got %0d expected 0", count); end
    endtask

`ifdef FLOAT_STICKY_FLAGS_EN
    task automatic test_sticky();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        checks++; if (sticky_flags !== 5'h00) begin failures++; $display("FAIL sticky_initial_clear: got %h expected 00", sticky_flags); end
        ready_in = 1'b1;
        push_one({16'h0, NAN_H}, 5'h10);
        push_one({16'h0, INF_H}, 5'h04);
        checks++; if (sticky_flags !== 5'h14) begin failures++; $display("FAIL sticky_accum: got %h expected 14", sticky_flags); end
        clear_flags = 1'b1;
        step();
        checks++; if (sticky_flags !== 5'h00) begin failures++; $display("FAIL sticky_clear: got %h expected 00", sticky_flags); end
        push_one({16'h0, ZERO_H}, 5'h01);
        clear_flags = 1'b0;
        checks++; if (sticky_flags !== 5'h01) begin failures++; $display("FAIL sticky_clear_push: got %h expected 01", sticky_flags); end
        step();
        ready_in = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL sticky_drained: got %0d expected 0", count); end
    endtask
`endif

    task automatic test_back_to_back();
        ready_in = 1'b0;
        push_one(32'hA001, 5'h01);
        exp_q.push_back({32'hA001, 5'h01});
        push_one(32'hA002, 5'h02);
        exp_q.push_back({32'hA002, 5'h02});
        ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            valid_in = 1'b1; result_in = 32'hC000 + 32'(i); flags_in = 5'(i);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back({32'hC000 + 32'(i), 5'(i)});
            checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", count); end
            checks++; if ({result, flags} !== exp_q[0]) begin failures++; $display("FAIL b2b_head: got %h expected %h", {result, flags}, exp_q[0]); end
        end
        valid_in = 1'b0;
        while (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++; if ({result, flags} !== exp_e) begin failures++; $display("FAIL b2b_drain: got %h expected %h", {result, flags}, exp_e); end
            step();
        end
        ready_in = 1'b0;
    endtask

    task automatic test_mid_reset();
        ready_in = 1'b0;
        push_one(32'h5101, 5'h03);
        push_one(32'h5102, 5'h05);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL midrst_pre_count: got %0d expected 2", count); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", count); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", valid_out); end
        checks++; if ({result, flags} !== 37'h0) begin failures++; $display("FAIL midrst_head: got %h expected 0", {result, flags}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL midrst_no_stale: got %b expected 0", valid_out); end
        checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", ready_out); end
        push_one(32'h3555, 5'h02);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL midrst_new_count: got %0d expected 1", count); end
        checks++; if ({result, flags} !== {32'h3555, 5'h02}) begin failures++; $display("FAIL midrst_new_head: got %h expected %h", {result, flags}, {32'h3555, 5'h02}); end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop_push();
`ifdef FLOAT_STICKY_FLAGS_EN
        test_sticky();
`endif
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
